sca_reg_seq: RTL

Scalar register and vector sequencing unit for the vector ASIP decode/execute boundary. Consumes the 3-bit scalar-register opcode and 32-bit immediate produced by the instruction decoder. Holds the loop-index registers I and J and the vector length N. For vector instructions (SUMFV, MULFV, LDV), it generates one element-index beat per element toward the vector datapath and stalls the front end until the sequence completes.

---
 rtl/sca_reg_seq_if.sv | 33 +++
 rtl/sca_reg_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sca_reg_seq_if.sv
// Decode/execute boundary bundle for sca_reg_seq: op intake, register view
// and the element-beat handshake toward the vector datapath.
interface sca_reg_seq_if #(
    parameter int IDX_W = 8
);
    logic             op_valid;
    logic [2:0]       sca_reg_op;
    logic [31:0]      imm;
    logic             stall;
    logic [IDX_W-1:0] reg_i;
    logic [IDX_W-1:0] reg_j;
    logic [IDX_W-1:0] reg_n;
    logic             i_wrap;
    logic             j_wrap;
    logic             seq_valid;
    logic             seq_ready;
    logic [1:0]       seq_op;
    logic [IDX_W-1:0] seq_idx;
    logic             seq_last;
    logic             seq_done;

    modport master (
        output op_valid, sca_reg_op, imm, seq_ready,
        input  stall, reg_i, reg_j, reg_n, i_wrap, j_wrap,
        input  seq_valid, seq_op, seq_idx, seq_last, seq_done
    );

    modport slave (
        input  op_valid, sca_reg_op, imm, seq_ready,
        output stall, reg_i, reg_j, reg_n, i_wrap, j_wrap,
        output seq_valid, seq_op, seq_idx, seq_last, seq_done
    );
endinterface

// File: rtl/sca_reg_seq.sv
// Scalar I/J/N registers and vector element sequencer.
// Define SCA_REG_SEQ_ILLEGAL_EN to add the sticky illegal_op output.
module sca_reg_seq #(
    parameter int IDX_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    sca_reg_seq_if.slave  bus
`ifdef SCA_REG_SEQ_ILLEGAL_EN
    ,
    output logic          illegal_op
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_INCRI = 3'b000;
    localparam logic [2:0] OP_INCRJ = 3'b001;
    localparam logic [2:0] OP_SETN  = 3'b010;
    localparam logic [2:0] OP_SUMFV = 3'b011;
    localparam logic [2:0] OP_MULFV = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;
    localparam logic [2:0] OP_LDV   = 3'b111;

    localparam logic [IDX_W-1:0] ONE   = 1;
    localparam logic [IDX_W:0]   ONE_W = 1;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [1:0]       op_q, op_d;
    logic             i_wrap_q, i_wrap_d;
    logic             j_wrap_q, j_wrap_d;
    logic [IDX_W:0]   i_inc, j_inc;
    logic             i_ovf, j_ovf;
    logic             last;
    logic [2:0]       op;
    logic             unused_imm;

    assign op         = bus.sca_reg_op;
    assign i_inc      = {1'b0, i_q} + ONE_W;
    assign j_inc      = {1'b0, j_q} + ONE_W;
    assign i_ovf      = i_inc >= {1'b0, n_q};
    assign j_ovf      = j_inc >= {1'b0, n_q};
    assign last       = idx_q == (len_q - ONE);
    assign unused_imm = ^bus.imm[31:IDX_W];

`ifdef SCA_REG_SEQ_ILLEGAL_EN
    logic ill_q, ill_d;
    assign illegal_op = ill_q;
`endif

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        n_d      = n_q;
        idx_d    = idx_q;
        len_d    = len_q;
        op_d     = op_q;
        i_wrap_d = 1'b0;
        j_wrap_d = 1'b0;
`ifdef SCA_REG_SEQ_ILLEGAL_EN
        ill_d    = ill_q;
`endif
        unique case (state_q)
            S_RUN: begin
                if (bus.seq_ready) begin
                    if (last) state_d = S_DONE;
                    else      idx_d   = idx_q + ONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (bus.op_valid) begin
                    unique case (1'b1)
                        op == OP_INCRI: begin
                            i_d      = i_ovf ? '0 : i_inc[IDX_W-1:0];
                            i_wrap_d = i_ovf;
                        end
                        op == OP_INCRJ: begin
                            j_d      = j_ovf ? '0 : j_inc[IDX_W-1:0];
                            j_wrap_d = j_ovf;
                        end
                        op == OP_SETN: begin
                            n_d = bus.imm[IDX_W-1:0];
                            i_d = '0;
                            j_d = '0;
                        end
                        op == OP_SUMFV,
                        op == OP_MULFV,
                        op == OP_LDV: begin
                            op_d    = (op == OP_SUMFV) ? 2'b00 :
                                      (op == OP_MULFV) ? 2'b01 : 2'b10;
                            len_d   = n_q;
                            idx_d   = '0;
                            // An empty vector skips straight to the done pulse
                            state_d = (n_q == '0) ? S_DONE : S_RUN;
                        end
                        op == OP_NOP: ;
                        default: begin
`ifdef SCA_REG_SEQ_ILLEGAL_EN
                            ill_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            op_q     <= '0;
            i_wrap_q <= 1'b0;
            j_wrap_q <= 1'b0;
`ifdef SCA_REG_SEQ_ILLEGAL_EN
            ill_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            op_q     <= op_d;
            i_wrap_q <= i_wrap_d;
            j_wrap_q <= j_wrap_d;
`ifdef SCA_REG_SEQ_ILLEGAL_EN
            ill_q    <= ill_d;
`endif
        end
    end

    assign bus.stall     = state_q != S_IDLE;
    assign bus.seq_valid = state_q == S_RUN;
    assign bus.seq_last  = (state_q == S_RUN) && last;
    assign bus.seq_done  = state_q == S_DONE;
    assign bus.seq_idx   = idx_q;
    assign bus.seq_op    = op_q;
    assign bus.reg_i     = i_q;
    assign bus.reg_j     = j_q;
    assign bus.reg_n     = n_q;
    assign bus.i_wrap    = i_wrap_q;
    assign bus.j_wrap    = j_wrap_q;
endmodule
